// File: rtl/intr_pkg.sv
// Shared parameters, FSM state type and priority helper for the interrupt controller.
package intr_pkg;

    localparam int unsigned NUM_SRC = 3;
    localparam int unsigned LVL_W   = 2;
    localparam int unsigned DEPTH_W = 2;

    localparam logic [LVL_W-1:0] LVL_NONE = '0;

    typedef enum logic {
        IDLE,
        REQ
    } state_e;

    // Highest pending level strictly above lvl_floor; LVL_NONE if there is none.
    function automatic logic [LVL_W-1:0] highest_above(
        input logic [NUM_SRC-1:0] pend,
        input logic [LVL_W-1:0]   lvl_floor
    );
        logic [LVL_W-1:0] best;
        best = LVL_NONE;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (pend[k] && (LVL_W'(k + 1) > lvl_floor)) begin
                best = LVL_W'(k + 1);
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/intr_edge_detect.sv
// Rising-edge detector for one interrupt source: registers the raw input and
// flags a 0->1 transition against the registered copy.
module intr_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic in_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in;
        end
    end

    assign rise = in & ~in_q;

endmodule

// File: rtl/intr_controller.sv
// Nested fixed-priority interrupt controller: edge-latched pending bits, an
// IDLE/REQ request FSM and a small in-service stack tracking the active level.
module intr_controller
    import intr_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               ie,
    input  logic               intr_ack,
    input  logic               uret,
    output logic               IntrRequest,
    output logic [LVL_W-1:0]   IntNo,
    output logic [LVL_W-1:0]   clrNo,
    output logic [LVL_W-1:0]   cur_level
);

    logic [NUM_SRC-1:0] rise;

    state_e               state_q, state_d;
    logic [NUM_SRC-1:0]   pend_q, pend_d;
    logic [LVL_W-1:0]     intno_q, intno_d;
    logic [LVL_W-1:0]     cur_q, cur_d;
    logic [LVL_W-1:0]     stack_q [NUM_SRC];
    logic [LVL_W-1:0]     stack_d [NUM_SRC];
    logic [DEPTH_W-1:0]   depth_q, depth_d;

    logic [LVL_W-1:0]     elig_c;
    logic                 push_c;
    logic                 pop_c;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_edge
        intr_edge_detect u_edge (
            .clk  (clk),
            .rst  (rst),
            .in   (irq_in[k]),
            .rise (rise[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            intno_q <= LVL_NONE;
            cur_q   <= LVL_NONE;
            depth_q <= '0;
            stack_q <= '{default: LVL_NONE};
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            intno_q <= intno_d;
            cur_q   <= cur_d;
            depth_q <= depth_d;
            stack_q <= stack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        intno_d = intno_q;
        cur_d   = cur_q;
        depth_d = depth_q;
        stack_d = stack_q;

        elig_c = ie ? highest_above(pend_q, cur_q) : LVL_NONE;
        push_c = (state_q == REQ) && intr_ack;
        pop_c  = uret && (depth_q != '0);

        unique case (state_q)
            IDLE: begin
                if (elig_c != LVL_NONE) begin
                    state_d = REQ;
                    intno_d = elig_c;
                end
            end
            REQ: begin
                if (intr_ack || (elig_c == LVL_NONE)) begin
                    state_d = IDLE;
                    intno_d = LVL_NONE;
                end else if (elig_c > intno_q) begin
                    intno_d = elig_c;
                end
            end
            default: begin
                state_d = IDLE;
                intno_d = LVL_NONE;
            end
        endcase

        // Pop before push so a uret+ack cycle replaces the top entry in place.
        if (pop_c) begin
            depth_d = depth_q - 2'd1;
            cur_d   = (depth_q >= 2'd2) ? stack_q[depth_q - 2'd2] : LVL_NONE;
        end
        if (push_c && (depth_d != DEPTH_W'(NUM_SRC))) begin
            stack_d[depth_d] = intno_q;
            depth_d          = depth_d + 2'd1;
            cur_d            = intno_q;
        end

        // A new edge on the source being acknowledged keeps it pending.
        if (push_c) begin
            pend_d[intno_q - 2'd1] = 1'b0;
        end
        pend_d = pend_d | rise;
    end

    // Pushed levels strictly increase, so a push into a full stack is a design error.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push_c && !pop_c && (depth_q == DEPTH_W'(NUM_SRC))));
        end
    end

    assign IntrRequest = (state_q == REQ);
    assign IntNo       = intno_q;
    assign cur_level   = cur_q;
    assign clrNo       = uret ? cur_q : LVL_NONE;

endmodule

// File: doc/intr_controller.md
INTR_CONTROLLER -- requirements
Module: intr_controller

Interface
REQ-001 SHALL expose: clk  in  1  system clock, all state changes on rising edge.
REQ-002 SHALL expose: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL expose: irq_in  in  3  raw interrupt sources; bit k is source k+1.
REQ-004 SHALL expose: ie  in  1  global interrupt enable from CSR.
REQ-005 SHALL expose: intr_ack  in  1  CPU has taken the trap for the current IntNo this cycle.
REQ-006 SHALL expose: uret  in  1  CPU retiring uret this cycle.
REQ-007 SHALL expose: IntrRequest  out  1  interrupt request to CPU.
REQ-008 SHALL expose: IntNo  out  2  requested level, 1..3; 0 means none.
REQ-009 SHALL expose: clrNo  out  2  level being cleared this cycle; 0 means none.
REQ-010 SHALL expose: cur_level  out  2  level in service, top of the nesting stack; 0 means none.

Function
REQ-011 SHALL detect rising edges on each irq_in bit, one cycle after the input registers, and set pending[k] on each edge.
REQ-012 SHALL use fixed priority: level 3 highest, level 1 lowest.
REQ-013 SHALL define eligible as the highest pending level that is strictly greater than cur_level, and only while ie=1.
REQ-014 SHALL implement FSM IDLE/REQ:
- IDLE to REQ when an eligible level exists.
- REQ to IDLE on intr_ack, or when ie=0, or when no eligible level remains.
REQ-015 SHALL drive IntrRequest=1 exactly in REQ, with IntNo equal to the eligible level; IntNo=0 in IDLE.
REQ-016 In REQ, IntNo SHALL change only to a higher level; a new lower-priority edge SHALL NOT alter it.
REQ-017 On intr_ack in REQ, the controller SHALL:
- clear pending[IntNo];
- push IntNo onto a 3-entry in-service stack;
- make cur_level = IntNo on the next cycle.
REQ-018 intr_ack in IDLE SHALL be ignored.
REQ-019 clrNo SHALL equal cur_level combinationally when uret=1, and 0 otherwise.
REQ-020 On uret the stack SHALL pop, so cur_level becomes the previous entry, or 0, next cycle.
REQ-021 uret with an empty stack SHALL give clrNo=0 and change no state.
REQ-022 When uret and intr_ack occur in the same cycle, the controller SHALL pop first, then push the acked IntNo; stack depth is unchanged.
REQ-023 When an edge and an intr_ack clear hit the same source in the same cycle, set SHALL win and pending stays 1.
REQ-024 Stack overflow SHALL be impossible because pushed levels are strictly increasing; an assertion SHALL flag any push at depth 3.
REQ-025 ie=0 SHALL suppress requests but retain pending bits and the stack.

Reset
REQ-026 rst=1 SHALL clear pending, the edge registers, the stack and depth, and return the FSM to IDLE.
REQ-027 After rst=1, outputs SHALL be IntrRequest=0, IntNo=0, cur_level=0, and clrNo=0 unless uret.
REQ-028 rst SHALL override intr_ack, uret and edges arriving in the same cycle.

Structure
REQ-029 Package intr_pkg SHALL hold NUM_SRC=3, LVL_W=2, LVL_NONE=0, and the FSM state enum {IDLE, REQ}.
REQ-030 The per-source edge detector SHALL be sub-module intr_edge_detect (clk, rst, in, rise), instantiated NUM_SRC times.

Verification
REQ-031 Single interrupt: pulse irq_in=3'b001 with ie=1 -> IntrRequest=1, IntNo=1 within 2 cycles; ack -> cur_level=1; uret -> clrNo=1 that cycle and cur_level=0 next.
REQ-032 Nesting: level 1 in service, then irq_in[2] edge -> IntNo=3 request; ack -> cur_level=3; uret -> clrNo=3, cur_level=1; uret -> clrNo=1, cur_level=0.
REQ-033 No preemption: level 2 in service, then irq_in[0] edge -> IntrRequest stays 0; after uret -> IntNo=1 requested.
REQ-034 Upgrade: in REQ with IntNo=1, irq_in[1] edge before ack -> IntNo=2; ack -> pending[0] still 1, pending[1] cleared.
REQ-035 Simultaneous: cur_level=1 in REQ with IntNo=3, intr_ack=uret=1 -> clrNo=1, cur_level=3 next cycle, depth 1.
REQ-036 Reset mid-service: depth 2, rst pulse -> all outputs 0, no request until a new edge arrives.
